phold_result_writer: RTL and testbench

PHOLD_RESULT_WRITER -- requirements
Module: phold_result_writer

---
 rtl/phold_result_writer_pkg.sv | 36 +++
 rtl/phold_result_writer_if.sv | 41 ++++
 rtl/phold_result_writer_sat_counter.sv | 36 +++
 rtl/phold_result_writer.sv | 162 ++++++++++++++++
 tb/tb_phold_result_writer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/phold_result_writer_pkg.sv
// -----------------------------------------------------------------------------
// phold_result_writer_pkg
// Shared definitions for the PHOLD result writer: memory-channel command and
// size encodings, result-record geometry, FSM state type and an address helper.
// -----------------------------------------------------------------------------
package phold_result_writer_pkg;

    // Memory request / response command encodings
    localparam logic [2:0] MC_CMD_WRITE       = 3'd2;
    localparam logic [2:0] MC_CMD_WR_COMPLETE = 3'd3;

    // Request size encoding for a full 8-byte word
    localparam logic [1:0] MC_SIZE_8B = 2'd3;

    // Result record: three 64-bit words laid out back to back
    localparam int RESULT_WORDS = 3;
    localparam int WORD_STRIDE  = 8;

    typedef logic [1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(RESULT_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_DONE
    } state_e;

    // Byte address of result word idx; 48-bit wrap, carry out discarded.
    function automatic logic [47:0] word_addr(input logic [47:0] base, input idx_t idx);
        return base + (48'(idx) * 48'(WORD_STRIDE));
    endfunction

endpackage

// File: rtl/phold_result_writer_if.sv
// -----------------------------------------------------------------------------
// phold_result_writer_if
// Memory request/response channel used to write the result record.
//   mc_rq_* : request  (master drives, slave asserts mc_rq_stall)
//   mc_rs_* : response (slave drives, master asserts mc_rs_stall)
// Modports: master = result writer side, slave = memory side.
// -----------------------------------------------------------------------------
interface phold_result_writer_if #(
    parameter int MC_RTNCTL_WIDTH = 32
);
    logic                       mc_rq_vld;
    logic [2:0]                 mc_rq_cmd;
    logic [3:0]                 mc_rq_scmd;
    logic [47:0]                mc_rq_vadr;
    logic [1:0]                 mc_rq_size;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic [63:0]                mc_rq_data;
    logic                       mc_rq_flush;
    logic                       mc_rq_stall;

    logic                       mc_rs_vld;
    logic [2:0]                 mc_rs_cmd;
    logic [3:0]                 mc_rs_scmd;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic [63:0]                mc_rs_data;
    logic                       mc_rs_stall;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
               mc_rs_data
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
               mc_rs_data
    );
endinterface

// File: rtl/phold_result_writer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear and count enable.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_clr      : load CLEAR_VAL (wins over i_en)
//   i_en       : increment by one, holding at all-ones
//   o_count    : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= CLEAR_VAL;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/phold_result_writer.sv
// -----------------------------------------------------------------------------
// phold_result_writer
// Counts simulation cycles and sent/received events between a start pulse and
// an end pulse, then writes a three-word result record to memory, one write
// outstanding at a time:
//   word0 @ addr+0  = {32'h0, cycle_cnt}
//   word1 @ addr+8  = {sent_cnt, rcv_cnt}
//   word2 @ addr+16 = gvt_final (zero-extended)
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : pulse, IDLE -> COUNT, clears counters
//   addr                       : record base address (8-byte aligned)
//   gvt                        : global virtual time, captured at end pulse
//   rtn_vld                    : pulse, COUNT -> record write-out
//   sent_msg_vld, rcv_msg_vld  : event strobes counted while in COUNT
//   mc                         : memory request/response channel (master)
//   busy                       : high whenever not IDLE
//   done                       : one-cycle pulse after the last write completes
// -----------------------------------------------------------------------------
module phold_result_writer
    import phold_result_writer_pkg::*;
#(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int TIME_WID        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [47:0]          addr,
    input  logic [TIME_WID-1:0]  gvt,
    input  logic                 rtn_vld,
    input  logic                 sent_msg_vld,
    input  logic                 rcv_msg_vld,
    phold_result_writer_if.master mc,
    output logic                 busy,
    output logic                 done
);

    state_e              r_state;
    state_e              w_state_nxt;
    idx_t                r_idx;
    logic [TIME_WID-1:0] r_gvt_final;
    logic [47:0]         r_base;

    logic [31:0] w_cycle_cnt;
    logic [31:0] w_sent_cnt;
    logic [31:0] w_rcv_cnt;

    logic w_clr;
    logic w_counting;
    logic w_rsp_match;
    logic w_end;

    // Response payload and scmd carry nothing a write completion needs.
    logic w_unused_rs;
    assign w_unused_rs = ^{mc.mc_rs_scmd, mc.mc_rs_data};

    assign w_clr       = (r_state == ST_IDLE) && start;
    assign w_counting  = (r_state == ST_COUNT);
    assign w_end       = w_counting && rtn_vld;
    assign w_rsp_match = (r_state == ST_WR_RSP) && mc.mc_rs_vld &&
                         (mc.mc_rs_cmd == MC_CMD_WR_COMPLETE) &&
                         (mc.mc_rs_rtnctl == MC_RTNCTL_WIDTH'(r_idx));

    // Every COUNT cycle is counted, including the one carrying rtn_vld.
    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_en    (w_counting),
        .o_count (w_cycle_cnt)
    );

    sat_counter #(.WIDTH(32)) u_sent_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_en    (w_counting && sent_msg_vld),
        .o_count (w_sent_cnt)
    );

    sat_counter #(.WIDTH(32)) u_rcv_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_en    (w_counting && rcv_msg_vld),
        .o_count (w_rcv_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Base address is captured with gvt so the request fields cannot move
    // under a stall even if the addr input changes during write-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_gvt_final <= '0;
            r_base      <= '0;
        end else if (w_clr) begin
            r_gvt_final <= '0;
        end else if (w_end) begin
            r_idx       <= '0;
            r_gvt_final <= gvt;
            r_base      <= addr;
        end else if (w_rsp_match && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt     = r_state;
        mc.mc_rq_vld    = 1'b0;
        mc.mc_rq_cmd    = MC_CMD_WRITE;
        mc.mc_rq_scmd   = 4'd0;
        mc.mc_rq_size   = MC_SIZE_8B;
        mc.mc_rq_flush  = 1'b0;
        mc.mc_rq_rtnctl = MC_RTNCTL_WIDTH'(r_idx);
        mc.mc_rq_vadr   = word_addr(r_base, r_idx);
        mc.mc_rq_data   = 64'd0;
        mc.mc_rs_stall  = 1'b0;
        busy            = (r_state != ST_IDLE);
        done            = 1'b0;

        case (r_idx)
            2'd0:    mc.mc_rq_data = {32'h0, w_cycle_cnt};
            2'd1:    mc.mc_rq_data = {w_sent_cnt, w_rcv_cnt};
            default: mc.mc_rq_data = 64'(r_gvt_final);
        endcase

        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (rtn_vld) w_state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                mc.mc_rq_vld = 1'b1;
                if (!mc.mc_rq_stall) w_state_nxt = ST_WR_RSP;
            end
            ST_WR_RSP: begin
                if (w_rsp_match) begin
                    w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_WR_REQ;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_phold_result_writer.sv
// -----------------------------------------------------------------------------
// tb_phold_result_writer
// Scoreboard bench: stimulus pushes the expected write requests when it ends
// a counting window; a monitor pops and compares on every accepted request.
// -----------------------------------------------------------------------------
module tb_phold_result_writer;
    import phold_result_writer_pkg::*;

    typedef struct {
        logic [47:0] vadr;
        logic [63:0] data;
        logic [31:0] rtnctl;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] addr = '0;
    logic [15:0] gvt = '0;
    logic        rtn_vld = 1'b0;
    logic        sent_msg_vld = 1'b0;
    logic        rcv_msg_vld = 1'b0;
    logic        busy;
    logic        done;

    logic        sat_clr = 1'b0;
    logic        sat_en = 1'b0;
    logic [31:0] sat_count;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    exp_wr_t sb_q[$];

    phold_result_writer_if #(.MC_RTNCTL_WIDTH(32)) mc_if ();

    phold_result_writer #(.MC_RTNCTL_WIDTH(32), .TIME_WID(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .addr         (addr),
        .gvt          (gvt),
        .rtn_vld      (rtn_vld),
        .sent_msg_vld (sent_msg_vld),
        .rcv_msg_vld  (rcv_msg_vld),
        .mc           (mc_if),
        .busy         (busy),
        .done         (done)
    );

    // Counter pre-loaded near the top so saturation is reachable quickly.
    sat_counter #(.WIDTH(32), .CLEAR_VAL(32'hFFFF_FFFE)) u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (sat_clr),
        .i_en    (sat_en),
        .o_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 ns after the falling edge, after stimulus settles.
    always begin
        @(negedge clk);
        #1;
        if (done) done_cnt++;
        if (mc_if.mc_rq_vld && !mc_if.mc_rq_stall) begin
            acc_cnt++;
            check("sb_has_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_wr_t e;
                e = sb_q.pop_front();
                check("wr_vadr",   64'(mc_if.mc_rq_vadr), 64'(e.vadr));
                check("wr_data",   mc_if.mc_rq_data, e.data);
                check("wr_rtnctl", 64'(mc_if.mc_rq_rtnctl), 64'(e.rtnctl));
                check("wr_ctl", 64'({mc_if.mc_rq_cmd, mc_if.mc_rq_scmd,
                                     mc_if.mc_rq_size, mc_if.mc_rq_flush}),
                      64'({3'd2, 4'd0, 2'd3, 1'b0}));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push3(input logic [47:0] a0, input logic [63:0] d0,
                         input logic [47:0] a1, input logic [63:0] d1,
                         input logic [47:0] a2, input logic [63:0] d2);
        sb_q.push_back('{vadr: a0, data: d0, rtnctl: 32'd0});
        sb_q.push_back('{vadr: a1, data: d1, rtnctl: 32'd1});
        sb_q.push_back('{vadr: a2, data: d2, rtnctl: 32'd2});
    endtask

    task automatic pulse_start(input logic [47:0] a);
        addr  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic count_cycles(input int n, input logic s, input logic r);
        sent_msg_vld = s;
        rcv_msg_vld  = r;
        repeat (n) tick();
        sent_msg_vld = 1'b0;
        rcv_msg_vld  = 1'b0;
    endtask

    task automatic end_sim(input logic [15:0] g);
        gvt     = g;
        rtn_vld = 1'b1;
        tick();
        rtn_vld = 1'b0;
        check("rq_latency_1cyc", 64'(mc_if.mc_rq_vld), 64'd1);
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!(mc_if.mc_rq_vld && !mc_if.mc_rq_stall) && (n < 50)) begin
            tick();
            n++;
        end
        check("accept_timeout", 64'(n >= 50), 64'd0);
        tick();
    endtask

    task automatic respond(input logic [31:0] rc, input logic [2:0] cmd);
        mc_if.mc_rs_vld    = 1'b1;
        mc_if.mc_rs_cmd    = cmd;
        mc_if.mc_rs_rtnctl = rc;
        tick();
        mc_if.mc_rs_vld    = 1'b0;
    endtask

    task automatic write_out_plain();
        for (int i = 0; i < 3; i++) begin
            wait_accept();
            tick();
            respond(32'(i), 3'd3);
        end
        check("done_pulse", 64'({done, busy}), 64'b11);
        tick();
        check("done_clear", 64'({done, busy}), 64'b00);
    endtask

    initial begin
        mc_if.mc_rq_stall  = 1'b0;
        mc_if.mc_rs_vld    = 1'b0;
        mc_if.mc_rs_cmd    = 3'd0;
        mc_if.mc_rs_scmd   = 4'd0;
        mc_if.mc_rs_rtnctl = '0;
        mc_if.mc_rs_data   = '0;

        repeat (3) tick();
        check("rst_outputs", 64'({busy, done, mc_if.mc_rq_vld, mc_if.mc_rs_stall}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Record 1: 100 COUNT cycles, no events
        pulse_start(48'h1000);
        check("busy_after_start", 64'(busy), 64'd1);
        push3(48'h1000, 64'd100, 48'h1008, 64'd0, 48'h1010, 64'd4001);
        count_cycles(99, 1'b0, 1'b0);
        end_sim(16'd4001);
        check("first_vadr", 64'(mc_if.mc_rq_vadr), 64'h1000);
        write_out_plain();
        check("done_once_r1", 64'(done_cnt), 64'd1);

        // rtn_vld in IDLE must be ignored
        rtn_vld = 1'b1;
        tick();
        rtn_vld = 1'b0;
        tick();
        check("rtn_in_idle", 64'({busy, mc_if.mc_rq_vld}), 64'd0);

        // Record 2: mixed strobes, stray start, stall, bad responses
        pulse_start(48'h1000);
        push3(48'h1000, 64'd17, 48'h1008, 64'h0000000F_0000000A, 48'h1010, 64'h1234);
        count_cycles(10, 1'b1, 1'b1);
        count_cycles(5, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        end_sim(16'h1234);
        sent_msg_vld = 1'b1;   // strobes outside COUNT must not count
        rcv_msg_vld  = 1'b1;
        wait_accept();
        respond(32'd0, 3'd3);
        mc_if.mc_rq_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("stall_vld",  64'(mc_if.mc_rq_vld), 64'd1);
            check("stall_vadr", 64'(mc_if.mc_rq_vadr), 64'h1008);
            check("stall_data", mc_if.mc_rq_data, 64'h0000000F_0000000A);
            tick();
        end
        check("stall_no_accept", 64'(acc_cnt), 64'd4);
        mc_if.mc_rq_stall = 1'b0;
        wait_accept();
        respond(32'd2, 3'd3);
        check("bad_rtnctl_ignored", 64'({busy, mc_if.mc_rq_vld}), 64'b10);
        respond(32'd1, 3'd1);
        check("bad_cmd_ignored", 64'({busy, mc_if.mc_rq_vld}), 64'b10);
        respond(32'd1, 3'd3);
        check("good_rsp_advance", 64'(mc_if.mc_rq_vld), 64'd1);
        check("idx2_vadr", 64'(mc_if.mc_rq_vadr), 64'h1010);
        wait_accept();
        respond(32'd2, 3'd3);
        check("done_pulse_r2", 64'(done), 64'd1);
        tick();
        sent_msg_vld = 1'b0;
        rcv_msg_vld  = 1'b0;
        check("acc_after_r2", 64'(acc_cnt), 64'd6);

        // Record 3: reset while waiting for the first response
        pulse_start(48'h2000);
        push3(48'h2000, 64'd6, 48'h2008, 64'd0, 48'h2010, 64'h0055);
        count_cycles(5, 1'b0, 1'b0);
        end_sim(16'h0055);
        wait_accept();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({busy, mc_if.mc_rq_vld, done}), 64'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        respond(32'd0, 3'd3);
        repeat (10) tick();
        check("no_req_after_rst", 64'(acc_cnt), 64'd7);
        check("idle_after_rst", 64'(busy), 64'd0);

        // Record 4: base address wraps at 48 bits
        pulse_start(48'hFFFF_FFFF_FFF8);
        push3(48'hFFFF_FFFF_FFF8, 64'd4, 48'h0, 64'd4, 48'h8, 64'hFFFF);
        count_cycles(3, 1'b0, 1'b1);
        rcv_msg_vld = 1'b1;
        end_sim(16'hFFFF);
        rcv_msg_vld = 1'b0;
        write_out_plain();

        // Saturation of the counter building block
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_preload", 64'(sat_count), 64'hFFFF_FFFE);
        sat_en = 1'b1;
        tick();
        check("sat_reach_max", 64'(sat_count), 64'hFFFF_FFFF);
        repeat (2) tick();
        sat_en = 1'b0;
        check("sat_hold_max", 64'(sat_count), 64'hFFFF_FFFF);

        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("total_accepts", 64'(acc_cnt), 64'd10);
        check("total_done", 64'(done_cnt), 64'd3);
        check("rs_stall_zero", 64'(mc_if.mc_rs_stall), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", checks);
        $fatal(1, "timeout");
    end

endmodule
